// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcodes, writeback selects and control-word helper
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WRITE_IMM,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL,
    CL_MOV_IMM,
    CL_MOV_REG,
    CL_ADD,
    CL_CMP,
    CL_AND,
    CL_MVN
  } iclass_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_PC    = 2'b01;
  localparam logic [1:0] WB_IMM8  = 2'b10;
  localparam logic [1:0] WB_MDATA = 2'b11;

  typedef struct packed {
    logic [2:0] r_addr;
    logic [2:0] w_addr;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_status;
    logic [1:0] wb_sel;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] shift_op;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a given state; everything not listed stays zero
  function automatic ctrl_t ctrl_for(input state_t st, input iclass_t cl,
                                     input logic [1:0] op, input logic [2:0] rn,
                                     input logic [2:0] rd, input logic [1:0] sh,
                                     input logic [2:0] rm);
    ctrl_t c;
    c = '0;
    case (st)
      LOAD_A: begin
        c.r_addr = rn;
        c.en_a   = 1'b1;
      end
      LOAD_B: begin
        c.r_addr = rm;
        c.en_b   = 1'b1;
      end
      EXEC: begin
        c.shift_op  = sh;
        c.alu_op    = (cl == CL_MOV_REG) ? 2'b00 : op;
        c.sel_a     = (cl == CL_MOV_REG);
        c.en_c      = (cl != CL_CMP);
        c.en_status = (cl == CL_CMP);
      end
      WRITE_REG: begin
        c.w_addr = rd;
        c.wb_sel = WB_C;
        c.w_en   = 1'b1;
      end
      WRITE_IMM: begin
        c.w_addr = rn;
        c.wb_sel = WB_IMM8;
        c.w_en   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// rtl/cpu_controller_instr_decoder.sv - field extraction, instruction class and immediates
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // classify opcode/op pairs; anything outside the ISA is illegal
  always_comb begin
    iclass = CL_ILLEGAL;
    if (ir[15:13] == OPC_MOV) begin
      if (op == OP_MOV_IMM)      iclass = CL_MOV_IMM;
      else if (op == OP_MOV_REG) iclass = CL_MOV_REG;
    end else if (ir[15:13] == OPC_ALU) begin
      case (op)
        OP_ADD:  iclass = CL_ADD;
        OP_CMP:  iclass = CL_CMP;
        OP_AND:  iclass = CL_AND;
        default: iclass = CL_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register and Moore sequencer driving the datapath
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  r_addr,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic [1:0]  wb_sel,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      state;
  logic [15:0] ir;
  ctrl_t       ctrl_q;
  iclass_t     iclass;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;

  instr_decoder u_dec (
    .ir     (ir),
    .iclass (iclass),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  // control word for the state being entered, from the current (stable) IR
  function automatic ctrl_t ctl(input state_t nx);
    return ctrl_for(nx, iclass, op, rn, rd, sh, rm);
  endfunction

  // sequencer: IR capture only while idle, outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= WAIT;
      ir     <= '0;
      ctrl_q <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (load) ir <= in;
          if (s) begin
            state  <= DECODE;
            ctrl_q <= ctl(DECODE);
          end
        end
        DECODE: begin
          case (iclass)
            CL_MOV_IMM: begin
              state  <= WRITE_IMM;
              ctrl_q <= ctl(WRITE_IMM);
            end
            CL_ADD, CL_CMP, CL_AND: begin
              state  <= LOAD_A;
              ctrl_q <= ctl(LOAD_A);
            end
            CL_MOV_REG, CL_MVN: begin
              state  <= LOAD_B;
              ctrl_q <= ctl(LOAD_B);
            end
            default: begin
              state  <= WAIT;
              ctrl_q <= ctl(WAIT);
            end
          endcase
        end
        LOAD_A: begin
          state  <= LOAD_B;
          ctrl_q <= ctl(LOAD_B);
        end
        LOAD_B: begin
          state  <= EXEC;
          ctrl_q <= ctl(EXEC);
        end
        EXEC: begin
          if (iclass == CL_CMP) begin
            state  <= WAIT;
            ctrl_q <= ctl(WAIT);
          end else begin
            state  <= WRITE_REG;
            ctrl_q <= ctl(WRITE_REG);
          end
        end
        default: begin
          state  <= WAIT;
          ctrl_q <= ctl(WAIT);
        end
      endcase
    end
  end

  // enables are gated by reset so a reset edge never commits a write
  assign w         = (state == WAIT);
  assign r_addr    = ctrl_q.r_addr;
  assign w_addr    = ctrl_q.w_addr;
  assign w_en      = ctrl_q.w_en & rst_n;
  assign en_A      = ctrl_q.en_a & rst_n;
  assign en_B      = ctrl_q.en_b & rst_n;
  assign en_C      = ctrl_q.en_c & rst_n;
  assign en_status = ctrl_q.en_status & rst_n;
  assign wb_sel    = ctrl_q.wb_sel;
  assign sel_A     = ctrl_q.sel_a;
  assign sel_B     = ctrl_q.sel_b;
  assign shift_op  = ctrl_q.shift_op;
  assign ALU_op    = ctrl_q.alu_op;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  r_addr;
  logic [2:0]  w_addr;
  logic        w_en;
  logic        en_A;
  logic        en_B;
  logic        en_C;
  logic        en_status;
  logic [1:0]  wb_sel;
  logic        sel_A;
  logic        sel_B;
  logic [1:0]  shift_op;
  logic [1:0]  ALU_op;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  cpu_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (instr_in),
    .load      (load),
    .s         (s),
    .w         (w),
    .r_addr    (r_addr),
    .w_addr    (w_addr),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .wb_sel    (wb_sel),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .shift_op  (shift_op),
    .ALU_op    (ALU_op),
    .sximm8    (sximm8),
    .sximm5    (sximm5)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] v(input logic vw, input logic [2:0] ra, input logic [2:0] wa,
                                    input logic wen, input logic ea, input logic eb,
                                    input logic ec, input logic es, input logic [1:0] wb,
                                    input logic sa, input logic sb, input logic [1:0] shv,
                                    input logic [1:0] alu);
    return {vw, ra, wa, wen, ea, eb, ec, es, wb, sa, sb, shv, alu};
  endfunction

  function automatic logic [19:0] obs();
    return {w, r_addr, w_addr, w_en, en_A, en_B, en_C, en_status, wb_sel,
            sel_A, sel_B, shift_op, ALU_op};
  endfunction

  task automatic check20(input string tag, input logic [19:0] got, input logic [19:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // reference trace, one vector per cycle after the start edge
  task automatic push_expected(input logic [15:0] ins);
    logic [2:0] opc;
    logic [1:0] op;
    logic       mov_reg;
    logic       cmp;
    opc     = ins[15:13];
    op      = ins[12:11];
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    cmp     = (opc == 3'b101) && (op == 2'b01);
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(v(0, 0, ins[10:8], 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
    end else if (opc == 3'b101 || mov_reg) begin
      if (opc == 3'b101 && op != 2'b11)
        exp_q.push_back(v(0, ins[10:8], 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(v(0, ins[2:0], 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(v(0, 0, 0, 0, 0, 0, !cmp, cmp, 0, mov_reg, 0, ins[4:3],
                        mov_reg ? 2'b00 : op));
      if (!cmp) exp_q.push_back(v(0, 0, ins[7:5], 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // load+start one instruction, compare each cycle; optional mid-run load pulse or reset
  task automatic run(input string tag, input logic [15:0] ins, input int pulse_at,
                     input int rst_at);
    logic [19:0] e;
    push_expected(ins);
    @(negedge clk);
    instr_in = ins;
    load     = 1'b1;
    s        = 1'b1;
    @(posedge clk);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      load     = (i == pulse_at);
      instr_in = (i == pulse_at) ? 16'hFFFF : ins;
      s        = 1'b0;
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check20({tag, "_rst_gate"}, {w_en, en_A, en_B, en_C, en_status, 15'h0}, 20'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check20({tag, "_rst_state"}, obs(), v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check16({tag, "_rst_ir"}, sximm8 | sximm5, 16'h0000);
      end else begin
        e = exp_q.pop_front();
        check20($sformatf("%s_c%0d", tag, i), obs(), e);
      end
    end
    if (rst_at < 0) begin
      check16({tag, "_sximm8"}, sximm8, {{8{ins[7]}}, ins[7:0]});
      check16({tag, "_sximm5"}, sximm5, {{11{ins[4]}}, ins[4:0]});
    end
    instr_in = 16'h0000;
    load     = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    instr_in = 16'h0000;
    load     = 1'b0;
    s        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check20("reset_outputs", obs(), v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check16("reset_imm", sximm8 | sximm5, 16'h0000);

    run("mov_imm", 16'hD3FB, -1, -1);
    check16("mov_imm_value", sximm8, 16'hFFFB);
    run("add", 16'hA148, -1, -1);
    run("cmp", 16'hA900, -1, -1);
    run("mvn", 16'hB8E4, -1, -1);
    run("mov_reg", 16'hC0A6, -1, -1);
    run("illegal", 16'h0000, -1, -1);
    run("add_loadmid", 16'hA148, 1, -1);
    run("add_reset", 16'hA148, -1, 4);
    run("and", 16'hB1E3, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
